// File: rtl/qracc_window_sequencer.sv
// qracc_window_sequencer: convolution-window read sequencer for the QRAcc compute phase.
// Walks output pixels of a row tile (loop order rs, fy, ox, oy) and issues activation-buffer
// and feature-loader addresses over a valid/ready handshake, with vertical zero-padding.
// Optional macro QRACC_WINSEQ_STATS_EN adds stall_cycles_o / reads_issued_o counters.
module qracc_window_sequencer #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DIM_W      = 16,
    parameter int unsigned INTF_ELEMS = 16,
    parameter int unsigned FILT_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] ifmap_base_i,
    input  logic [ADDR_W-1:0] map_offset_i,
    input  logic [DIM_W-1:0]  ifmap_dimx_i,
    input  logic [DIM_W-1:0]  ifmap_dimy_i,
    input  logic [DIM_W-1:0]  num_in_ch_i,
    input  logic [DIM_W-1:0]  ofmap_dimx_i,
    input  logic [DIM_W-1:0]  row_start_i,
    input  logic [DIM_W-1:0]  row_end_i,
    input  logic [FILT_W-1:0] filt_x_i,
    input  logic [FILT_W-1:0] filt_y_i,
    input  logic [3:0]        stride_x_i,
    input  logic [3:0]        stride_y_i,
    input  logic [3:0]        pad_y_i,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              rd_pad_o,
    output logic [ADDR_W-1:0] fl_addr_o,
    output logic              win_last_o,
    output logic              busy_o,
    output logic              done_o
`ifdef QRACC_WINSEQ_STATS_EN
    ,
    output logic [31:0]       stall_cycles_o,
    output logic [31:0]       reads_issued_o
`endif
);

    localparam int unsigned LOG2_IE = $clog2(INTF_ELEMS);
    localparam int unsigned CW      = DIM_W + FILT_W;
    localparam int unsigned SW      = DIM_W + 6;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [DIM_W-1:0]  oy_r, ox_r;
    logic [FILT_W-1:0] fy_r;
    logic [CW-1:0]     rs_r;

    logic [ADDR_W-1:0] base_r, moff_r, rowstride_r, pixstride_r, flrow_r;
    logic [DIM_W-1:0]  iydim_r, oxdim_r, row_start_r, row_end_r;
    logic [FILT_W-1:0] fydim_r;
    logic [3:0]        sy_r, pad_r;
    logic [CW-1:0]     nrs_r;

    logic [CW-1:0]     cfx, nrs_calc;
    logic              run, fire;
    logic              rs_wrap, fy_wrap, ox_wrap;
    logic [SW-1:0]     iy;
    logic              pad_raw;
    logic [ADDR_W-1:0] iy_a, ox_a, fy_a, rs_a;

    assign cfx      = CW'(num_in_ch_i) * CW'(filt_x_i);
    assign nrs_calc = ((cfx - CW'(1)) >> LOG2_IE) + CW'(1);

    assign run  = (state == RUN);
    assign fire = run && rd_ready_i;

    assign rs_wrap = (rs_r == nrs_r - CW'(1));
    assign fy_wrap = (fy_r == fydim_r - FILT_W'(1));
    assign ox_wrap = (ox_r == oxdim_r - DIM_W'(1));

    // Two's-complement input row; the sign bit marks the top padding band.
    assign iy      = SW'(oy_r) * SW'(sy_r) + SW'(fy_r) - SW'(pad_r);
    assign pad_raw = iy[SW-1] || (iy >= SW'(iydim_r));

    assign iy_a = ADDR_W'(iy);
    assign ox_a = ADDR_W'(ox_r);
    assign fy_a = ADDR_W'(fy_r);
    assign rs_a = ADDR_W'(rs_r) << LOG2_IE;

    assign rd_valid_o = run;
    assign rd_pad_o   = run && pad_raw;
    assign rd_addr_o  = (run && !pad_raw) ?
                        (base_r + rowstride_r * iy_a + pixstride_r * ox_a + rs_a) : '0;
    assign fl_addr_o  = run ? (fy_a * flrow_r + rs_a + moff_r) : '0;
    assign win_last_o = run && rs_wrap && fy_wrap;
    assign busy_o     = (state != IDLE);
    assign done_o     = (state == DONE);

    // Capture configuration and derived strides once per sequence, in SETUP.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_r      <= '0;
            moff_r      <= '0;
            rowstride_r <= '0;
            pixstride_r <= '0;
            flrow_r     <= '0;
            iydim_r     <= '0;
            oxdim_r     <= '0;
            row_start_r <= '0;
            row_end_r   <= '0;
            fydim_r     <= '0;
            sy_r        <= '0;
            pad_r       <= '0;
            nrs_r       <= '0;
        end else if (state == SETUP && !clear_i) begin
            base_r      <= ifmap_base_i;
            moff_r      <= map_offset_i;
            rowstride_r <= ADDR_W'(num_in_ch_i) * ADDR_W'(ifmap_dimx_i);
            pixstride_r <= ADDR_W'(num_in_ch_i) * ADDR_W'(stride_x_i);
            flrow_r     <= ADDR_W'(cfx);
            iydim_r     <= ifmap_dimy_i;
            oxdim_r     <= ofmap_dimx_i;
            row_start_r <= row_start_i;
            row_end_r   <= row_end_i;
            fydim_r     <= filt_y_i;
            sy_r        <= stride_y_i;
            pad_r       <= pad_y_i;
            nrs_r       <= nrs_calc;
        end
    end

    // Sequence FSM and nested window counters, advanced only on an accepted read.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            state <= IDLE;
            oy_r  <= '0;
            ox_r  <= '0;
            fy_r  <= '0;
            rs_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) state <= SETUP;
                end
                SETUP: begin
                    oy_r  <= row_start_i;
                    ox_r  <= '0;
                    fy_r  <= '0;
                    rs_r  <= '0;
                    state <= (row_end_i < row_start_i) ? DONE : RUN;
                end
                RUN: begin
                    if (fire) begin
                        if (!rs_wrap) begin
                            rs_r <= rs_r + CW'(1);
                        end else begin
                            rs_r <= '0;
                            if (!fy_wrap) begin
                                fy_r <= fy_r + FILT_W'(1);
                            end else begin
                                fy_r <= '0;
                                if (!ox_wrap) begin
                                    ox_r <= ox_r + DIM_W'(1);
                                end else begin
                                    ox_r <= '0;
                                    if (oy_r == row_end_r) begin
                                        oy_r  <= row_start_r;
                                        state <= DONE;
                                    end else begin
                                        oy_r <= oy_r + DIM_W'(1);
                                    end
                                end
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef QRACC_WINSEQ_STATS_EN
    // Stall and accepted-read counters; cleared by an accepted start, held after done.
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start_i && !clear_i)) begin
            stall_cycles_o <= '0;
            reads_issued_o <= '0;
        end else begin
            if (run && !rd_ready_i) stall_cycles_o <= stall_cycles_o + 32'd1;
            if (fire)               reads_issued_o <= reads_issued_o + 32'd1;
        end
    end
`endif

endmodule
